// File: rtl/calibration_pkg.sv
// -----------------------------------------------------------------------------
// calibration_pkg
// Shared types, constants and helpers for the LED calibration pattern
// transmitter and its camera-side capture counterpart.
//
// Contents:
//   calibration_tx_state_t : step FSM states of the LED-side transmitter
//   calibration_rx_state_t : step FSM states of the camera-side capture block
//   DEFAULT_ON_COLOR       : GRB colour shown for an address bit of 1
//   DEFAULT_OFF_COLOR      : GRB colour shown for an address bit of 0
//   addr_bit(addr, idx)    : bit idx of the code displayed for LED address addr
//
// Build option: CALIB_GRAY_CODE_EN. When defined, addr_bit() returns bits of
// the Gray code of the address, so adjacent LEDs differ in a single bit and
// a blurred boundary corrupts at most one step. The capture side must then
// Gray-decode the accumulated value. When undefined, plain binary is used.
// -----------------------------------------------------------------------------
package calibration_pkg;

  // Widest LED address that addr_bit() accepts.
  localparam int unsigned ADDR_MAX_W = 32;

  localparam logic [23:0] DEFAULT_ON_COLOR  = 24'h00FF00;
  localparam logic [23:0] DEFAULT_OFF_COLOR = 24'hFF0000;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_STREAM,
    TX_WAIT_STRIP,
    TX_TRIGGER,
    TX_WAIT_CAP_START,
    TX_WAIT_CAP_DONE,
    TX_DONE
  } calibration_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_WAIT_FRAME,
    RX_CAPTURE,
    RX_ACCUMULATE,
    RX_DONE
  } calibration_rx_state_t;

  // The address must already be wrapped to LED_ADDRESS_WIDTH bits and
  // zero-extended, so the Gray shift pulls a 0 into the top address bit.
  function automatic logic addr_bit(input logic [ADDR_MAX_W-1:0] addr,
                                    input logic [4:0]            idx);
    logic [ADDR_MAX_W-1:0] code;
`ifdef CALIB_GRAY_CODE_EN
    code = addr ^ (addr >> 1);
`else
    code = addr;
`endif
    return code[idx];
  endfunction

endpackage

// File: rtl/led_color_streamer.sv
// -----------------------------------------------------------------------------
// led_color_streamer
// Streams one GRB colour per LED over a valid/ready handshake. LED i shows
// ON_COLOR when bit bit_index of its displayed address code is 1, OFF_COLOR
// otherwise. The LED address is i+ADDR_OFFSET, wrapped to LED_ADDRESS_WIDTH.
//
// Ports:
//   clk_pixel, rst_n : clock, asynchronous active-low reset
//   enable           : streaming is active (step FSM is in STREAM)
//   clear            : synchronous restart of the LED counter (start/abort)
//   bit_index        : address bit being displayed this step
//   color_out        : colour for the current LED (0 while not streaming)
//   color_valid      : color_out is valid
//   color_ready      : strip driver accepts color_out
//   color_last       : current LED is the last one of the frame
//   frame_done       : the last LED is being transferred this cycle
//
// Build option: CALIB_GRAY_CODE_EN selects Gray-coded addresses (see package).
// -----------------------------------------------------------------------------
module led_color_streamer
  import calibration_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter int unsigned ADDR_OFFSET       = 1,
  parameter logic [23:0] ON_COLOR          = DEFAULT_ON_COLOR,
  parameter logic [23:0] OFF_COLOR         = DEFAULT_OFF_COLOR,
  localparam int unsigned BIT_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [BIT_W-1:0] bit_index,
  output logic [23:0]      color_out,
  output logic             color_valid,
  input  logic             color_ready,
  output logic             color_last,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CNT_W-1:0] LAST_LED = CNT_W'(NUM_LEDS - 1);

  logic [CNT_W-1:0]             led_count;
  logic [LED_ADDRESS_WIDTH-1:0] led_addr;
  logic                         is_last;
  logic                         xfer;

  // Address arithmetic wraps at LED_ADDRESS_WIDTH bits.
  assign led_addr = LED_ADDRESS_WIDTH'(led_count) + LED_ADDRESS_WIDTH'(ADDR_OFFSET);

  // Everything below depends only on led_count and bit_index, which hold
  // during a stall, so colour and last stay stable while ready is low.
  assign is_last     = (led_count == LAST_LED);
  assign color_valid = enable;
  assign color_last  = enable && is_last;
  assign color_out   = !enable ? 24'h000000 :
                       addr_bit(ADDR_MAX_W'(led_addr), 5'(bit_index)) ? ON_COLOR : OFF_COLOR;
  assign xfer        = enable && color_ready;
  assign frame_done  = xfer && is_last;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      led_count <= '0;
    end else if (clear) begin
      led_count <= '0;
    end else if (xfer) begin
      led_count <= is_last ? '0 : led_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/calibration_pattern_tx.sv
// -----------------------------------------------------------------------------
// calibration_pattern_tx
// LED-side calibration sequencer. One step per address bit, MSB first: stream
// a frame whose colours encode that bit of every LED's address, wait for the
// strip to latch, trigger one capture step and wait for it to finish.
//
// Ports:
//   clk_pixel, rst_n          : clock, asynchronous active-low reset
//   start_calibration         : pulse, starts a sequence (honoured in IDLE only)
//   abort                     : level, returns to IDLE; overrides everything
//   color_out/valid/ready/last: colour stream to the strip driver
//   strip_done                : pulse, strip latch/reset period completed
//   start_calibration_step    : one-cycle trigger to the capture FSM
//   should_overwrite_latch    : level, high during the first (MSB) step
//   step_busy                 : capture FSM is not idle
//   bit_index                 : address bit currently displayed
//   busy                      : sequencer is not idle
//   done                      : one-cycle pulse when a sequence completes
//
// Build option: CALIB_GRAY_CODE_EN selects Gray-coded addresses (see package).
// -----------------------------------------------------------------------------
module calibration_pattern_tx
  import calibration_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter int unsigned ADDR_OFFSET       = 1,
  parameter logic [23:0] ON_COLOR          = DEFAULT_ON_COLOR,
  parameter logic [23:0] OFF_COLOR         = DEFAULT_OFF_COLOR,
  localparam int unsigned BIT_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             start_calibration,
  input  logic             abort,
  output logic [23:0]      color_out,
  output logic             color_valid,
  input  logic             color_ready,
  output logic             color_last,
  input  logic             strip_done,
  output logic             start_calibration_step,
  output logic             should_overwrite_latch,
  input  logic             step_busy,
  output logic [BIT_W-1:0] bit_index,
  output logic             busy,
  output logic             done
);

  localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(LED_ADDRESS_WIDTH - 1);

  calibration_tx_state_t state_q, state_d;
  logic [BIT_W-1:0]      bit_index_q, bit_index_d;
  logic                  stream_clear;
  logic                  frame_done;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      bit_index_q <= TOP_BIT;
    end else begin
      state_q     <= state_d;
      bit_index_q <= bit_index_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_index_d  = bit_index_q;
    stream_clear = 1'b0;

    if (abort) begin
      // The streamer's clear beats its transfer increment, so a handshake
      // in the abort cycle is dropped.
      state_d      = TX_IDLE;
      stream_clear = 1'b1;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          if (start_calibration) begin
            bit_index_d  = TOP_BIT;
            stream_clear = 1'b1;
            state_d      = TX_STREAM;
          end
        end
        TX_STREAM: begin
          if (frame_done) state_d = TX_WAIT_STRIP;
        end
        TX_WAIT_STRIP: begin
          if (strip_done) state_d = TX_TRIGGER;
        end
        TX_TRIGGER: begin
          state_d = TX_WAIT_CAP_START;
        end
        TX_WAIT_CAP_START: begin
          // Waiting for busy to rise first keeps a slow capture FSM from
          // being mistaken for a finished one.
          if (step_busy) state_d = TX_WAIT_CAP_DONE;
        end
        TX_WAIT_CAP_DONE: begin
          if (!step_busy) begin
            if (bit_index_q == '0) begin
              state_d = TX_DONE;
            end else begin
              bit_index_d = bit_index_q - BIT_W'(1);
              state_d     = TX_STREAM;
            end
          end
        end
        TX_DONE: begin
          state_d = TX_IDLE;
        end
        default: begin
          state_d = TX_IDLE;
        end
      endcase
    end
  end

  led_color_streamer #(
    .NUM_LEDS          (NUM_LEDS),
    .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH),
    .ADDR_OFFSET       (ADDR_OFFSET),
    .ON_COLOR          (ON_COLOR),
    .OFF_COLOR         (OFF_COLOR)
  ) u_streamer (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .enable      (state_q == TX_STREAM),
    .clear       (stream_clear),
    .bit_index   (bit_index_q),
    .color_out   (color_out),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .color_last  (color_last),
    .frame_done  (frame_done)
  );

  assign bit_index              = bit_index_q;
  assign busy                   = (state_q != TX_IDLE);
  assign done                   = (state_q == TX_DONE);
  assign start_calibration_step = (state_q == TX_TRIGGER);
  // Held as a level through the whole step so the capture FSM may sample it
  // whenever it reacts to the trigger.
  assign should_overwrite_latch = (state_q != TX_IDLE) && (bit_index_q == TOP_BIT);

endmodule

// File: tb/tb_calibration_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_calibration_pattern_tx
// Scoreboard bench for calibration_pattern_tx with NUM_LEDS=4,
// LED_ADDRESS_WIDTH=3, ADDR_OFFSET=1. Stimulus pushes hand-computed colours
// and trigger expectations into queues; a negedge monitor pops and compares
// whenever the DUT presents a colour or a capture trigger.
// Honours CALIB_GRAY_CODE_EN for the expected colour patterns.
// -----------------------------------------------------------------------------
module tb_calibration_pattern_tx;
  import calibration_pkg::*;

  localparam int NUM_LEDS          = 4;
  localparam int LED_ADDRESS_WIDTH = 3;
  localparam int ADDR_OFFSET       = 1;
  localparam int TOP               = LED_ADDRESS_WIDTH - 1;
  localparam logic [23:0] ON_C     = 24'h00FF00;
  localparam logic [23:0] OFF_C    = 24'hFF0000;

  if (NUM_LEDS + ADDR_OFFSET > (1 << LED_ADDRESS_WIDTH)) begin : g_cfg_bad
    initial begin
      $display("FAIL config: NUM_LEDS+ADDR_OFFSET exceeds the address space");
      $fatal(1);
    end
  end

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_calibration = 1'b0;
  logic        abort = 1'b0;
  logic        color_ready = 1'b0;
  logic        strip_done = 1'b0;
  logic        step_busy = 1'b0;
  logic [23:0] color_out;
  logic        color_valid, color_last, start_calibration_step;
  logic        should_overwrite_latch, busy, done;
  logic [1:0]  bit_index;

  calibration_pattern_tx #(
    .NUM_LEDS          (NUM_LEDS),
    .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH),
    .ADDR_OFFSET       (ADDR_OFFSET)
  ) dut (
    .clk_pixel              (clk_pixel),
    .rst_n                  (rst_n),
    .start_calibration      (start_calibration),
    .abort                  (abort),
    .color_out              (color_out),
    .color_valid            (color_valid),
    .color_ready            (color_ready),
    .color_last             (color_last),
    .strip_done             (strip_done),
    .start_calibration_step (start_calibration_step),
    .should_overwrite_latch (should_overwrite_latch),
    .step_busy              (step_busy),
    .bit_index              (bit_index),
    .busy                   (busy),
    .done                   (done)
  );

  initial forever #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [23:0] color;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  bit   trig_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   trig_seen  = 0;
  int   done_seen  = 0;
  bit   bp_mode    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived patterns, bit k of pat = LED k (addresses 1..4).
  function automatic logic exp_on(input int b, input int led);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef CALIB_GRAY_CODE_EN
    case (b)
      2:       pat = 4'b1000;
      1:       pat = 4'b1110;
      default: pat = 4'b0011;
    endcase
`else
    case (b)
      2:       pat = 4'b1000;
      1:       pat = 4'b0110;
      default: pat = 4'b0101;
    endcase
`endif
    return pat[led];
  endfunction

  task automatic push_colors(input int b, input int n);
    exp_t e;
    for (int led = 0; led < n; led++) begin
      e.color = exp_on(b, led) ? ON_C : OFF_C;
      e.last  = (led == NUM_LEDS - 1);
      exp_q.push_back(e);
    end
  endtask

  // Strip driver ready: always high, or random backpressure.
  initial forever begin
    @(posedge clk_pixel);
    #1;
    color_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: colour stream, capture triggers, done pulses.
  initial forever begin
    exp_t e;
    @(negedge clk_pixel);
    if (rst_n && !abort) begin
      if (color_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_color_valid", 32'(color_valid), 32'd0);
        end else if (color_ready) begin
          e = exp_q.pop_front();
          check("color_out", 32'(color_out), 32'(e.color));
          check("color_last", 32'(color_last), 32'(e.last));
        end else begin
          check("stall_color_out", 32'(color_out), 32'(exp_q[0].color));
          check("stall_color_last", 32'(color_last), 32'(exp_q[0].last));
        end
      end
      if (start_calibration_step) begin
        trig_seen++;
        if (trig_q.size() == 0)
          check("unexpected_trigger", 32'(start_calibration_step), 32'd0);
        else
          check("overwrite_latch", 32'(should_overwrite_latch), 32'(trig_q.pop_front()));
      end
      if (done) done_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic pulse_start();
    start_calibration = 1'b1;
    tick();
    start_calibration = 1'b0;
  endtask

  task automatic wait_valid(input logic level, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (color_valid == level) ok = 1'b1;
    end
    check(level ? "stream_start_timeout" : "stream_end_timeout", 32'(ok), 32'd1);
  endtask

  // One calibration step: stream, strip latch, trigger, capture handshake.
  task automatic run_step(input int b, input int gap, input int len);
    bit ok;
    push_colors(b, NUM_LEDS);
    trig_q.push_back(b == TOP);
    wait_valid(1'b1, 50);
    wait_valid(1'b0, 400);
    strip_done = 1'b1;
    tick();
    strip_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (start_calibration_step) ok = 1'b1;
      else tick();
    end
    check("trigger_timeout", 32'(ok), 32'd1);
    check("bit_index_at_trigger", 32'(bit_index), 32'(b));
    repeat (gap) tick();
    check("wait_cap_no_stream", 32'(color_valid), 32'd0);
    check("wait_cap_busy", 32'(busy), 32'd1);
    step_busy = 1'b1;
    repeat (len) tick();
    step_busy = 1'b0;
  endtask

  task automatic run_sequence(input int gap0, input int len0);
    int  done_before;
    bit  ok;
    done_before = done_seen;
    pulse_start();
    for (int b = TOP; b >= 0; b--)
      run_step(b, (b == TOP) ? gap0 : 2, (b == TOP) ? len0 : 5);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (done_seen > done_before) ok = 1'b1;
    end
    check("done_timeout", 32'(ok), 32'd1);
    repeat (3) tick();
    check("done_pulse_count", 32'(done_seen - done_before), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
    check("bit_index_held", 32'(bit_index), 32'd0);
    check("colors_pending", 32'(exp_q.size()), 32'd0);
    check("triggers_pending", 32'(trig_q.size()), 32'd0);
  endtask

  initial begin
    int done_before;
    int trig_before;

    // Reset state
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_color_valid", 32'(color_valid), 32'd0);
    check("rst_color_out", 32'(color_out), 32'd0);
    check("rst_bit_index", 32'(bit_index), 32'(TOP));
    rst_n = 1'b1;
    tick();

    // Plain streaming, no backpressure
    bp_mode = 1'b0;
    run_sequence(2, 5);

    // Random backpressure plus slow capture handshake on the first step
    bp_mode = 1'b1;
    run_sequence(20, 100);

    // Abort after two transfers of the bit1 step
    bp_mode = 1'b0;
    repeat (3) tick();
    done_before = done_seen;
    pulse_start();
    run_step(TOP, 2, 5);
    push_colors(TOP - 1, 2);
    trig_before = trig_seen;
    wait_valid(1'b1, 50);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_color_valid", 32'(color_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_colors_pending", 32'(exp_q.size()), 32'd0);
    repeat (20) tick();
    check("abort_no_done", 32'(done_seen - done_before), 32'd0);
    check("abort_no_trigger", 32'(trig_seen - trig_before), 32'd0);
    run_sequence(2, 5);

    // Asynchronous reset while waiting for the strip
    repeat (3) tick();
    pulse_start();
    push_colors(TOP, NUM_LEDS);
    wait_valid(1'b1, 50);
    wait_valid(1'b0, 50);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_color_valid", 32'(color_valid), 32'd0);
    check("arst_color_out", 32'(color_out), 32'd0);
    check("arst_color_last", 32'(color_last), 32'd0);
    check("arst_step", 32'(start_calibration_step), 32'd0);
    check("arst_overwrite", 32'(should_overwrite_latch), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bit_index", 32'(bit_index), 32'(TOP));
    check("arst_colors_pending", 32'(exp_q.size()), 32'd0);
    trig_before = trig_seen;
    tick();
    rst_n = 1'b1;
    tick();
    strip_done = 1'b1;
    tick();
    strip_done = 1'b0;
    repeat (10) tick();
    check("arst_strip_done_ignored", 32'(trig_seen - trig_before), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
